mbist_march_gen: RTL and testbench

Parametrised March C- memory BIST controller for single-port synchronous SRAMs, the successor to the fixed 8Kx8 BIST in the AHB-SRAMC macro wrapper. It runs the full March C- sequence once per selected data background (solid, checkerboard, address-parity stripe), and it muxes test/functional RAM controls on `b_te`. It also reports first-failure diagnostics (address, element, background, syndrome) and a saturating fail count, and has an explicit start/done handshake.

---
 rtl/mbist_pkg.sv | 31 +++
 rtl/mbist_addr_gen.sv | 46 ++++
 rtl/mbist_march_gen.sv | 185 ++++++++++++++++++
 tb/tb_mbist_march_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST: FSM states, element table and data backgrounds.
package mbist_pkg;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RD, S_CMP, S_WR, S_DONE} state_e;

  typedef enum logic [2:0] {E0 = 3'd0, E1 = 3'd1, E2 = 3'd2, E3 = 3'd3, E4 = 3'd4, E5 = 3'd5} elem_e;

  typedef enum logic [1:0] {BG_SOLID = 2'd0, BG_CHECKER = 2'd1, BG_STRIPE = 2'd2} bg_e;

  typedef struct packed {
    logic down;
    logic rd_pol;
    logic wr_pol;
    logic has_rd;
    logic has_wr;
  } elem_cfg_t;

  // Polarity 1 means the inverted background (the "1" pattern).
  function automatic elem_cfg_t elem_cfg(input elem_e e);
    case (e)
      E0:      return elem_cfg_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      E1:      return elem_cfg_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      E2:      return elem_cfg_t'{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      E3:      return elem_cfg_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      E4:      return elem_cfg_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      E5:      return elem_cfg_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default: return elem_cfg_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with terminal detect, plus the background pattern for the current address.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  down_i,
  input  bg_e                   bg_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  term_o,
  output logic [DATA_WIDTH-1:0] pat_o
);

  localparam logic [DATA_WIDTH-1:0] CHECKER = {(DATA_WIDTH/2){2'b01}};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i)      addr_d = down_i ? '1 : '0;
    else if (step_i) addr_d = down_i ? addr_q - 1'b1 : addr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign term_o = down_i ? (addr_q == '0) : (addr_q == '1);

  always_comb begin
    case (bg_i)
      BG_SOLID:   pat_o = '0;
      BG_CHECKER: pat_o = CHECKER;
      BG_STRIPE:  pat_o = CHECKER ^ {DATA_WIDTH{addr_q[0]}};
      default:    pat_o = '0;
    endcase
  end

endmodule

// File: rtl/mbist_march_gen.sv
// March C- BIST controller for a single-port synchronous SRAM with first-fail diagnostics
// and a test/functional control mux selected by b_te.
module mbist_march_gen
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int WE_WIDTH     = 1,
  parameter int NUM_BG       = 3,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                  b_clk,
  input  logic                  b_rst_n,
  input  logic                  b_te,
  input  logic                  b_start,
  input  logic [ADDR_WIDTH-1:0] addr_fun,
  input  logic [WE_WIDTH-1:0]   wen_fun,
  input  logic                  cen_fun,
  input  logic                  oen_fun,
  input  logic [DATA_WIDTH-1:0] data_fun,
  input  logic [DATA_WIDTH-1:0] ram_read_out,
  output logic [ADDR_WIDTH-1:0] addr_test,
  output logic [WE_WIDTH-1:0]   wen_test,
  output logic                  cen_test,
  output logic                  oen_test,
  output logic [DATA_WIDTH-1:0] data_test,
  output logic                  b_busy,
  output logic                  b_done,
  output logic                  b_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [1:0]            fail_bg,
  output logic [DATA_WIDTH-1:0] fail_syn,
  output logic [7:0]            fail_cnt
);

  localparam logic [1:0] LAST_BG = 2'(NUM_BG - 1);

  state_e                state_q, state_d;
  elem_e                 elem_q, elem_d, fail_elem_q, fail_elem_d;
  bg_e                   bg_q, bg_d, fail_bg_q, fail_bg_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_syn_q, fail_syn_d;
  logic [7:0]            fail_cnt_q, fail_cnt_d;

  logic                  addr_load, addr_step, adv, term, miscmp;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] pat0, exp_rd, wr_pat;
  elem_cfg_t             cfg;

  assign cfg    = elem_cfg(elem_q);
  assign exp_rd = cfg.rd_pol ? ~pat0 : pat0;
  assign wr_pat = cfg.wr_pol ? ~pat0 : pat0;
  assign miscmp = b_te && (ram_read_out != exp_rd);

  mbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_addr (
    .clk_i  (b_clk),
    .rst_ni (b_rst_n),
    .load_i (addr_load),
    .step_i (addr_step),
    .down_i (cfg.down),
    .bg_i   (bg_q),
    .addr_o (addr),
    .term_o (term),
    .pat_o  (pat0)
  );

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    bg_d        = bg_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_bg_d   = fail_bg_q;
    fail_syn_d  = fail_syn_q;
    fail_cnt_d  = fail_cnt_q;
    addr_load   = 1'b0;
    addr_step   = 1'b0;
    adv         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (b_te && b_start) begin
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = E0;
          fail_bg_d   = BG_SOLID;
          fail_syn_d  = '0;
          fail_cnt_d  = '0;
          bg_d        = BG_SOLID;
          elem_d      = E0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        addr_load = 1'b1;
        state_d   = cfg.has_rd ? S_RD : S_WR;
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (miscmp) begin
          fail_d     = 1'b1;
          fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
          if (fail_cnt_q == 8'd0) begin
            fail_addr_d = addr;
            fail_elem_d = elem_q;
            fail_bg_d   = bg_q;
            fail_syn_d  = exp_rd ^ ram_read_out;
          end
        end
        if (miscmp && STOP_ON_FAIL != 0) state_d = S_DONE;
        else if (cfg.has_wr)              state_d = S_WR;
        else                              adv     = 1'b1;
      end
      S_WR:    adv     = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // End of a per-address step: next address, next element, next background or finish.
    if (adv) begin
      if (!term) begin
        addr_step = 1'b1;
        state_d   = cfg.has_rd ? S_RD : S_WR;
      end else if (elem_q == E5) begin
        if (bg_q == LAST_BG) begin
          state_d = S_DONE;
        end else begin
          bg_d    = bg_e'(bg_q + 2'd1);
          elem_d  = E0;
          state_d = S_SETUP;
        end
      end else begin
        elem_d  = elem_e'(elem_q + 3'd1);
        state_d = S_SETUP;
      end
    end

    if (!b_te) begin
      state_d   = S_IDLE;
      addr_load = 1'b0;
      addr_step = 1'b0;
    end
  end

  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= E0;
      bg_q        <= BG_SOLID;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= E0;
      fail_bg_q   <= BG_SOLID;
      fail_syn_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      bg_q        <= bg_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_bg_q   <= fail_bg_d;
      fail_syn_q  <= fail_syn_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign addr_test = b_te ? addr : addr_fun;
  assign wen_test  = b_te ? {WE_WIDTH{state_q != S_WR}} : wen_fun;
  assign cen_test  = b_te ? 1'b0 : cen_fun;
  assign oen_test  = b_te ? 1'b0 : oen_fun;
  assign data_test = b_te ? wr_pat : data_fun;

  assign b_busy    = (state_q == S_SETUP) || (state_q == S_RD) || (state_q == S_CMP) || (state_q == S_WR);
  assign b_done    = (state_q == S_DONE);
  assign b_fail    = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_bg   = fail_bg_q;
  assign fail_syn  = fail_syn_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march_gen.sv
// Bench for mbist_march_gen: three 16x8 instances (1 bg, 3 bg, 1 bg stop-on-fail), each with its own RAM model and fault.
module tb_mbist_march_gen;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n, te, start, cen_f, oen_f;
  logic [AW-1:0] addr_f;
  logic [0:0]    wen_f;
  logic [DW-1:0] data_f;

  logic [AW-1:0] addr_t [ND];
  logic [0:0]    wen_t  [ND];
  logic [ND-1:0] cen_t, oen_t, busy, done, fail;
  logic [DW-1:0] data_t [ND];
  logic [AW-1:0] faddr  [ND];
  logic [2:0]    felem  [ND];
  logic [1:0]    fbg    [ND];
  logic [DW-1:0] fsyn   [ND];
  logic [7:0]    fcnt   [ND];

  int fmode [ND];  // 0 none, 1 stuck-at-1 bit3 @5 on read, 2 write @6 inverts @7
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q;

    mbist_march_gen #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(1),
      .NUM_BG((g == 1) ? 3 : 1), .STOP_ON_FAIL((g == 2) ? 1 : 0)
    ) u_dut (
      .b_clk(clk), .b_rst_n(rst_n), .b_te(te), .b_start(start),
      .addr_fun(addr_f), .wen_fun(wen_f), .cen_fun(cen_f), .oen_fun(oen_f), .data_fun(data_f),
      .ram_read_out(q),
      .addr_test(addr_t[g]), .wen_test(wen_t[g]), .cen_test(cen_t[g]), .oen_test(oen_t[g]),
      .data_test(data_t[g]),
      .b_busy(busy[g]), .b_done(done[g]), .b_fail(fail[g]),
      .fail_addr(faddr[g]), .fail_elem(felem[g]), .fail_bg(fbg[g]), .fail_syn(fsyn[g]),
      .fail_cnt(fcnt[g])
    );

    always @(posedge clk) begin
      if (!cen_t[g]) begin
        if (wen_t[g] == 1'b0) begin
          mem[addr_t[g]] <= data_t[g];
          if (fmode[g] == 2 && addr_t[g] == 4'd6) mem[7] <= ~mem[7];
        end else begin
          q <= mem[addr_t[g]] | ((fmode[g] == 1 && addr_t[g] == 4'd5) ? 8'h08 : 8'h00);
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", d, nm, act, exp);
    end
  endtask

  typedef struct {
    logic te; logic [AW-1:0] a; logic w; logic c; logic o; logic [DW-1:0] dt;
    logic [AW-1:0] ea; logic ew; logic ec; logic eo; logic [DW-1:0] ed;
  } mux_t;

  typedef struct {
    int dut; int fm; int busy; int fail; int cnt; int fa; int fe; int fb; int fs;
  } run_t;

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run(input run_t r, input string nm);
    int bc, guard;
    for (int i = 0; i < ND; i++) fmode[i] = (i == r.dut) ? r.fm : 0;
    pulse_start();
    bc = 0;
    guard = 0;
    while (!done[r.dut] && guard < 3000) begin
      if (busy[r.dut]) bc++;
      guard++;
      @(negedge clk);
    end
    chk({nm, " done"}, r.dut, int'(done[r.dut]), 1);
    chk({nm, " busy cycles"}, r.dut, bc, r.busy);
    chk({nm, " b_fail"}, r.dut, int'(fail[r.dut]), r.fail);
    if (r.cnt >= 0) chk({nm, " fail_cnt"}, r.dut, int'(fcnt[r.dut]), r.cnt);
    chk({nm, " fail_addr"}, r.dut, int'(faddr[r.dut]), r.fa);
    chk({nm, " fail_elem"}, r.dut, int'(felem[r.dut]), r.fe);
    chk({nm, " fail_bg"}, r.dut, int'(fbg[r.dut]), r.fb);
    chk({nm, " fail_syn"}, r.dut, int'(fsyn[r.dut]), r.fs);
    guard = 0;
    while (busy != '0 && guard < 3000) begin
      guard++;
      @(negedge clk);
    end
    chk({nm, " all idle"}, r.dut, int'(busy), 0);
  endtask

  mux_t mv [6];
  run_t rv [6];

  initial begin
    mv[0] = '{1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 8'h3C, 4'hA, 1'b0, 1'b1, 1'b0, 8'h3C};
    mv[1] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 8'hC3, 4'h5, 1'b1, 1'b0, 1'b1, 8'hC3};
    mv[2] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 8'hFF, 4'hF, 1'b0, 1'b0, 1'b0, 8'hFF};
    mv[3] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 8'h3C, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00};
    mv[4] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 8'hFF, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00};
    mv[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 8'h00};

    rv[0] = '{0, 0, 246, 0,  0, 0, 0, 0, 8'h00};
    rv[1] = '{0, 1, 246, 1,  3, 5, 1, 0, 8'h08};
    rv[2] = '{2, 1,  35, 1,  1, 5, 1, 0, 8'h08};
    rv[3] = '{1, 2, 738, 1, -1, 7, 1, 0, 8'hFF};
    rv[4] = '{1, 1, 738, 1,  8, 5, 1, 0, 8'h08};
    rv[5] = '{1, 0, 738, 0,  0, 0, 0, 0, 8'h00};

    te = 1'b0; start = 1'b0; addr_f = '0; wen_f = 1'b1; cen_f = 1'b1; oen_f = 1'b1; data_f = '0;
    for (int i = 0; i < ND; i++) fmode[i] = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("reset busy", d, int'(busy[d]), 0);
      chk("reset done", d, int'(done[d]), 0);
      chk("reset fail", d, int'(fail[d]), 0);
      chk("reset cnt",  d, int'(fcnt[d]), 0);
      chk("reset faddr", d, int'(faddr[d]), 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      te = mv[i].te; addr_f = mv[i].a; wen_f = mv[i].w; cen_f = mv[i].c; oen_f = mv[i].o; data_f = mv[i].dt;
      #1;
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("mux%0d addr", i), d, int'(addr_t[d]), int'(mv[i].ea));
        chk($sformatf("mux%0d wen", i),  d, int'(wen_t[d]),  int'(mv[i].ew));
        chk($sformatf("mux%0d cen", i),  d, int'(cen_t[d]),  int'(mv[i].ec));
        chk($sformatf("mux%0d oen", i),  d, int'(oen_t[d]),  int'(mv[i].eo));
        chk($sformatf("mux%0d data", i), d, int'(data_t[d]), int'(mv[i].ed));
      end
    end

    te = 1'b1; cen_f = 1'b1;
    for (int i = 0; i < 6; i++) run(rv[i], $sformatf("run%0d", i));

    // b_te dropped mid-E2 of a faulty run on dut0.
    fmode[0] = 1; fmode[1] = 0; fmode[2] = 0;
    pulse_start();
    repeat (80) @(negedge clk);
    te = 1'b0; addr_f = 4'h9; wen_f = 1'b0; cen_f = 1'b1; oen_f = 1'b0; data_f = 8'h5A;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("te drop busy", d, int'(busy[d]), 0);
      chk("te drop done", d, int'(done[d]), 0);
      chk("te drop addr", d, int'(addr_t[d]), 9);
      chk("te drop wen",  d, int'(wen_t[d]), 0);
      chk("te drop cen",  d, int'(cen_t[d]), 1);
      chk("te drop oen",  d, int'(oen_t[d]), 0);
      chk("te drop data", d, int'(data_t[d]), 8'h5A);
    end
    chk("te drop fail kept",  0, int'(fail[0]), 1);
    chk("te drop faddr kept", 0, int'(faddr[0]), 5);
    chk("te drop felem kept", 0, int'(felem[0]), 1);
    chk("te drop cnt kept",   0, int'(fcnt[0]), 1);
    te = 1'b1; wen_f = 1'b1;
    run('{0, 0, 246, 0, 0, 0, 0, 0, 8'h00}, "rerun after te drop");

    // Asynchronous reset mid-E3 of a faulty run on dut0.
    fmode[0] = 1; fmode[1] = 0; fmode[2] = 0;
    pulse_start();
    repeat (130) @(negedge clk);
    chk("pre-reset fail", 0, int'(fail[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("async rst busy",  d, int'(busy[d]), 0);
      chk("async rst done",  d, int'(done[d]), 0);
      chk("async rst fail",  d, int'(fail[d]), 0);
      chk("async rst cnt",   d, int'(fcnt[d]), 0);
      chk("async rst faddr", d, int'(faddr[d]), 0);
      chk("async rst addr",  d, int'(addr_t[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run('{0, 0, 246, 0, 0, 0, 0, 0, 8'h00}, "rerun after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
